sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Two-to-one arbiter for SRAM-like requests. It merges the CPU's instruction-fetch port and its load/store port into the single SRAM-like master port of the AXI bridge. It tracks every accepted transaction in an in-order outstanding queue, so each `data_ok`/`rdata` returns to the requester that issued it. It also holds back any read whose word address matches a write that is still in flight.

## Interface
Parameters:
- `DEPTH`, default 2: outstanding-queue entries; legal values are 2 or 4.

Ports:
- `aclk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `inst_req`, `inst_wr` in 1 each; `inst_size` in 2; `inst_wstrb` in 4; `inst_addr`, `inst_wdata` in 32: fetch-side request.
- `inst_addr_ok`, `inst_data_ok` out 1 each; `inst_rdata` out 32: fetch-side response.
- `data_req`, `data_wr` in 1 each; `data_size` in 2; `data_wstrb` in 4; `data_addr`, `data_wdata` in 32: load/store request.
- `data_addr_ok`, `data_data_ok` out 1 each; `data_rdata` out 32: load/store response.
- `bus_req`, `bus_wr` out 1 each; `bus_size` out 2; `bus_wstrb` out 4; `bus_addr`, `bus_wdata` out 32: request to the bridge.
- `bus_addr_ok`, `bus_data_ok` in 1 each; `bus_rdata` in 32: bridge response. Responses arrive in acceptance order.
- `resp_err` out 1: one-cycle pulse when `bus_data_ok` arrives with the queue empty.

## Operation
- Handshake (SRAM-like): a requester holds `req` and its payload stable until `addr_ok`. A request is accepted in the cycle where `req && addr_ok`.
- Eligibility: a source is eligible when its `req` is high, the queue is not full, and no RAW block applies.
- RAW block: a read (`wr=0`) is blocked while any valid queue entry has `wr=1` and `addr[31:2]` equal to the read's `addr[31:2]`.
- Grant: combinational, fixed priority data > inst, with two exceptions.
  - Lock override: the `lock_valid`/`lock_src` register forces the grant to `lock_src`.
  - Lock set: when `bus_req && !bus_addr_ok`, the lock is set to the current source for the next cycle.
  - Lock clear: on `bus_addr_ok`, or when the locked source drops `req`.
- Mux: `bus_*` request fields are driven from the granted source. All `bus_*` request fields are 0 when `bus_req=0`.
- `bus_req` equals the granted source's `req`, gated by the full check and the RAW block.
- `x_addr_ok = bus_addr_ok && bus_req && grant==x`. The ungranted source sees `addr_ok=0`.
- Queue push: on acceptance, push `{src, wr, addr[31:2]}`.
- Queue pop: on `bus_data_ok`, pop the head and route the response.
  - `x_data_ok = bus_data_ok && head.src==x`.
  - `inst_rdata` and `data_rdata` both equal `bus_rdata` at all times.
  - Write completions also pop and raise `data_data_ok`.
- The queue is a circular buffer with read/write pointers of width log2(DEPTH)+1. Full and empty are decided by the MSB comparison.

## Timing
- Reset:
  - Queue is empty and pointers are 0.
  - Lock is cleared.
  - `resp_err` is 0.
  - All combinational outputs are 0 while both `req` inputs are low.
- Request path is zero-latency: `bus_req` and `addr_ok` follow their inputs in the same cycle.
- The earliest `data_ok` is the cycle after acceptance, as set by the bridge.
- Full: `bus_req=0`, so neither source gets `addr_ok`.
- Push and pop in the same cycle:
  - Allowed, and the count is unchanged.
  - When the queue is full, a pop in that cycle does NOT enable a push. `full` is taken from registered state.
- RAW block release: the block is evaluated against registered queue entries. A write popping in cycle N releases the blocked read in cycle N+1.
- A blocked data read does not stall inst. inst may be granted that cycle if it is eligible.
- Pointer wrap-around: pointers wrap modulo 2·DEPTH. Full when the low bits are equal and the MSBs differ.
- `bus_data_ok` with the queue empty:
  - Pulse `resp_err` for one cycle.
  - Both `data_ok` outputs stay 0.
  - Pointers are unchanged.
- Reset mid-operation:
  - Outstanding entries are discarded and the lock is cleared.
  - The bridge and CPU are reset in the same cycle.

## Test plan
- Simultaneous requests:
  - Stimulus: inst read at 0x1c000000 and data read at 0x00001000, both in cycle 0, with `bus_addr_ok=1`.
  - Required: `data_addr_ok=1` in cycle 0, then `inst_addr_ok=1` in cycle 1.
  - Required: two `bus_data_ok` pulses route to data first (rdata 0xAAAA5555), then to inst.
- Lock hold:
  - Stimulus: inst request with `bus_addr_ok=0` for 3 cycles; data_req rises in cycle 1.
  - Required: `bus_addr` stays 0x1c000000 until accepted in cycle 3; data is granted in cycle 4.
- RAW block:
  - Stimulus: write to 0x00002004 accepted; data read of 0x00002006 follows; the write's `bus_data_ok` comes in cycle 5.
  - Required: the read's `bus_req=0` through cycle 5 and goes high in cycle 6.
  - Required: a read of 0x00002008 in the same window proceeds immediately.
- Full:
  - Stimulus: DEPTH=2, two accepted reads, no responses.
  - Required: third request sees `bus_req=0` and no `addr_ok`. After one `bus_data_ok`, it is accepted the next cycle.
  - Stimulus: pop and push in the same cycle at count 1. Required: count stays 1.
- Error and reset:
  - Stimulus: `bus_data_ok` with the queue empty. Required: `resp_err=1` for one cycle and no `data_ok`.
  - Stimulus: `reset` with 2 entries outstanding. Required: queue is empty next cycle, and a new request is accepted immediately.

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response port bundle: request fields flow master->slave, addr_ok/data_ok/rdata flow back.
// The arbiter is the slave on its CPU-facing ports and the master on its bridge-facing port.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// 2:1 SRAM-like arbiter (data > inst) with an in-order outstanding queue and RAW hold-off; zero-latency request path.
// Backpressure: no addr_ok while the queue is full, a RAW hazard applies, or the bridge withholds bus addr_ok.
module sram_req_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic               aclk,
    input  logic               reset,
    sram_req_arbiter_if.slave  inst,
    sram_req_arbiter_if.slave  data,
    sram_req_arbiter_if.master bus,
    output logic               resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          q_vld_q [DEPTH];
    logic          q_src_q [DEPTH];   // 1 = data port, 0 = inst port
    logic          q_wr_q  [DEPTH];
    logic [29:0]   q_wa_q  [DEPTH];

    logic          lock_vld_q, lock_vld_d;
    logic          lock_src_q;
    logic          resp_err_q;

    logic          empty, full;
    logic          inst_raw, data_raw;
    logic          inst_elig, data_elig;
    logic          gnt_data;
    logic          breq;
    logic          accept, pop;
    logic [AW-1:0] head, tail;

    logic          bus_wr_w;
    logic [1:0]    bus_size_w;
    logic [3:0]    bus_wstrb_w;
    logic [31:0]   bus_addr_w;
    logic [31:0]   bus_wdata_w;

    assign head  = rptr_q[AW-1:0];
    assign tail  = wptr_q[AW-1:0];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // Hazard check sees only registered entries, so a popping write frees the read one cycle later.
    always_comb begin
        inst_raw = 1'b0;
        data_raw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld_q[i] && q_wr_q[i]) begin
                if (!inst.wr && (q_wa_q[i] == inst.addr[31:2])) inst_raw = 1'b1;
                if (!data.wr && (q_wa_q[i] == data.addr[31:2])) data_raw = 1'b1;
            end
        end
    end

    assign inst_elig = inst.req && !full && !inst_raw;
    assign data_elig = data.req && !full && !data_raw;

    assign gnt_data = lock_vld_q ? lock_src_q : data_elig;
    assign breq     = gnt_data ? data_elig : inst_elig;
    assign accept   = breq && bus.addr_ok;
    assign pop      = bus.data_ok && !empty;

    always_comb begin
        bus_wr_w    = 1'b0;
        bus_size_w  = 2'b00;
        bus_wstrb_w = 4'h0;
        bus_addr_w  = 32'h0;
        bus_wdata_w = 32'h0;
        if (breq) begin
            if (gnt_data) begin
                bus_wr_w    = data.wr;
                bus_size_w  = data.size;
                bus_wstrb_w = data.wstrb;
                bus_addr_w  = data.addr;
                bus_wdata_w = data.wdata;
            end else begin
                bus_wr_w    = inst.wr;
                bus_size_w  = inst.size;
                bus_wstrb_w = inst.wstrb;
                bus_addr_w  = inst.addr;
                bus_wdata_w = inst.wdata;
            end
        end
    end

    assign bus.req   = breq;
    assign bus.wr    = bus_wr_w;
    assign bus.size  = bus_size_w;
    assign bus.wstrb = bus_wstrb_w;
    assign bus.addr  = bus_addr_w;
    assign bus.wdata = bus_wdata_w;

    assign inst.addr_ok = accept && !gnt_data;
    assign data.addr_ok = accept &&  gnt_data;
    assign inst.data_ok = pop && !q_src_q[head];
    assign data.data_ok = pop &&  q_src_q[head];
    assign inst.rdata   = bus.rdata;
    assign data.rdata   = bus.rdata;
    assign resp_err     = resp_err_q;

    assign wptr_d = wptr_q + {{AW{1'b0}}, accept};
    assign rptr_d = rptr_q + {{AW{1'b0}}, pop};

    // A stalled bus request pins the grant so its payload cannot switch under the bridge.
    assign lock_vld_d = breq && !bus.addr_ok;

    always_ff @(posedge aclk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            lock_vld_q <= 1'b0;
            lock_src_q <= 1'b0;
            resp_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_vld_q[i] <= 1'b0;
                q_src_q[i] <= 1'b0;
                q_wr_q[i]  <= 1'b0;
                q_wa_q[i]  <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lock_vld_q <= lock_vld_d;
            lock_src_q <= gnt_data;
            resp_err_q <= bus.data_ok && empty;
            if (pop) q_vld_q[head] <= 1'b0;
            if (accept) begin
                q_vld_q[tail] <= 1'b1;
                q_src_q[tail] <= gnt_data;
                q_wr_q[tail]  <= bus_wr_w;
                q_wa_q[tail]  <= bus_addr_w[31:2];
            end
        end
    end

endmodule
